// File: rtl/key_pkg.sv
// Shared timing defaults (50 MHz) and pressed-level helper
// for the front-panel key debouncer.
package key_pkg;

  localparam int unsigned SAMPLE_TIME_50M = 2000000;
  localparam int unsigned LONG_TIME_50M   = 50000000;
  localparam int unsigned REPEAT_TIME_50M = 10000000;

  function automatic logic pressed_level(
    input logic raw,
    input logic active_low
  );
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter, hold counter
// and registered press/release/long/repeat strobes.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned SAMPLE_TIME = SAMPLE_TIME_50M,
  parameter int unsigned LONG_TIME   = LONG_TIME_50M,
  parameter int unsigned REPEAT_TIME = REPEAT_TIME_50M,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned CNT_W       = $clog2(LONG_TIME + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic AL       = (ACTIVE_LOW != 0);
  localparam logic REP_ON   = (REPEAT_EN != 0);
  localparam logic IDLE_RAW = AL;

  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LONG_TIME - REPEAT_TIME);

  logic             sync1_q, sync2_q;
  logic             p;
  logic             state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             long_done_q, long_done_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             rep_q, rep_d;

  always_comb begin
    p       = pressed_level(sync2_q, AL);
    state_d = state_q;
    dcnt_d  = '0;
    if (p != state_q) begin
      if (dcnt_q == S_LAST) begin
        state_d = p;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    press_d = state_d & ~state_q;
    rel_d   = state_q & ~state_d;

    // A release accepted this cycle suppresses any due long/repeat strobe.
    hcnt_d      = '0;
    long_done_d = 1'b0;
    long_d      = 1'b0;
    rep_d       = 1'b0;
    if (state_q && state_d) begin
      long_done_d = long_done_q;
      if (hcnt_q == L_LAST) begin
        hcnt_d      = RELOAD;
        long_done_d = 1'b1;
        long_d      = ~long_done_q;
        rep_d       = long_done_q & REP_ON;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= IDLE_RAW;
      sync2_q     <= IDLE_RAW;
      state_q     <= 1'b0;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      sync1_q     <= key_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
      rep_q       <= rep_d;
    end
  end

  assign key_state     = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;

endmodule

// File: rtl/key_debounce_bank.sv
// N-channel front-panel key debouncer: one independent
// key_debounce_ch per key pin.
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 8,
  parameter int unsigned SAMPLE_TIME = SAMPLE_TIME_50M,
  parameter int unsigned LONG_TIME   = LONG_TIME_50M,
  parameter int unsigned REPEAT_TIME = REPEAT_TIME_50M,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned CNT_W       = $clog2(LONG_TIME + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .SAMPLE_TIME (SAMPLE_TIME),
      .LONG_TIME   (LONG_TIME),
      .REPEAT_TIME (REPEAT_TIME),
      .REPEAT_EN   (REPEAT_EN),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in[g]),
      .key_state     (key_state[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .long_pulse    (long_pulse[g]),
      .repeat_pulse  (repeat_pulse[g])
    );
  end

endmodule
